// File: rtl/mem_pkg.sv
// Shared types and constants for the wait-state memory responder.
package mem_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WAITS = 2'd1,
      RESP  = 2'd2
   } state_e;

   localparam int DEFAULT_DEPTH = 64;
   localparam int DEFAULT_WAIT  = 2;

   // Misaligned, or any address bit above the word index is set.
   function automatic logic addr_fault(
      input logic [31:0] adr,
      input int          aw
   );
      return (adr[1:0] != 2'b00) || ((adr >> (aw + 2)) != 32'd0);
   endfunction

endpackage

// File: rtl/mem_array.sv
// Word storage: synchronous write, combinational read, no reset.
module mem_array #(
   parameter int DEPTH = 64,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk_i,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [31:0]   wdata_i,
   input  logic [AW-1:0] raddr_i,
   output logic [31:0]   rdata_o
);

   logic [31:0] mem_q [DEPTH];

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/mem_responder.sv
// Multicycle memory responder: request latch, wait-state FSM,
// address fault check and registered completion outputs.
module mem_responder
   import mem_pkg::*;
#(
   parameter int DEPTH = DEFAULT_DEPTH,
   parameter int WAIT  = DEFAULT_WAIT
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req,
   input  logic        we,
   input  logic [31:0] adr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        ready,
   output logic        err,
   output logic        busy
);

   localparam int AW = $clog2(DEPTH);
   localparam bit NO_WAIT = (WAIT == 0);
   localparam logic [3:0] WLOAD = (WAIT > 0) ? 4'(WAIT - 1) : 4'd0;

   state_e      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        we_q, we_d;
   logic [31:0] adr_q, adr_d;
   logic [31:0] wdata_q, wdata_d;
   logic        ready_q, ready_d;
   logic        err_q, err_d;
   logic [31:0] rdata_q, rdata_d;

   logic        accept;
   logic        fault_cur;
   logic        fault_nxt;
   logic        enter_resp;
   logic        mem_we;
   logic [31:0] mem_rdata;

   assign accept    = (state_q == IDLE) && req;
   assign fault_cur = addr_fault(adr_q, AW);
   assign fault_nxt = addr_fault(adr_d, AW);

   // Inputs only matter in the IDLE cycle that accepts them.
   always_comb begin
      we_d    = we_q;
      adr_d   = adr_q;
      wdata_d = wdata_q;
      if (accept) begin
         we_d    = we;
         adr_d   = adr;
         wdata_d = wdata;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         we_q    <= 1'b0;
         adr_q   <= 32'd0;
         wdata_q <= 32'd0;
         ready_q <= 1'b0;
         err_q   <= 1'b0;
         rdata_q <= 32'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         we_q    <= we_d;
         adr_q   <= adr_d;
         wdata_q <= wdata_d;
         ready_q <= ready_d;
         err_q   <= err_d;
         rdata_q <= rdata_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE: begin
            if (req) begin
               if (fault_nxt || NO_WAIT) begin
                  state_d = RESP;
               end else begin
                  state_d = WAITS;
                  cnt_d   = WLOAD;
               end
            end
         end
         WAITS: begin
            if (cnt_q == 4'd0) begin
               state_d = RESP;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
            cnt_d   = 4'd0;
         end
      endcase
   end

   // Completion outputs are set on the edge that enters RESP.
   always_comb begin
      enter_resp = (state_d == RESP) && (state_q != RESP);
      ready_d    = enter_resp;
      err_d      = enter_resp && fault_nxt;
      rdata_d    = rdata_q;
      if (enter_resp && !we_d && !fault_nxt) begin
         rdata_d = mem_rdata;
      end
   end

   assign mem_we = (state_q == RESP) && we_q && !fault_cur;

   mem_array #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_mem (
      .clk_i   (clk),
      .we_i    (mem_we),
      .waddr_i (adr_q[AW+1:2]),
      .wdata_i (wdata_q),
      .raddr_i (adr_d[AW+1:2]),
      .rdata_o (mem_rdata)
   );

   assign rdata = rdata_q;
   assign ready = ready_q;
   assign err   = err_q;
   assign busy  = (state_q != IDLE);

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: WAIT=2 and WAIT=0 instances
// checked every cycle against a latency/queue level model.
module tb_mem_responder;

   logic        clk = 1'b0;
   logic        reset = 1'b1;

   logic        req1 = 1'b0, we1 = 1'b0;
   logic [31:0] adr1 = 32'd0, wdata1 = 32'd0;
   logic [31:0] rdata1;
   logic        ready1, err1, busy1;

   logic        req0 = 1'b0, we0 = 1'b0;
   logic [31:0] adr0 = 32'd0, wdata0 = 32'd0;
   logic [31:0] rdata0;
   logic        ready0, err0, busy0;

   int checks = 0;
   int failures = 0;
   bit chk_en = 1'b0;

   always #5 clk = ~clk;

   mem_responder #(.DEPTH(64), .WAIT(2)) u_dut (
      .clk   (clk),
      .reset (reset),
      .req   (req1),
      .we    (we1),
      .adr   (adr1),
      .wdata (wdata1),
      .rdata (rdata1),
      .ready (ready1),
      .err   (err1),
      .busy  (busy1)
   );

   mem_responder #(.DEPTH(64), .WAIT(0)) u_dut0 (
      .clk   (clk),
      .reset (reset),
      .req   (req0),
      .we    (we0),
      .adr   (adr0),
      .wdata (wdata0),
      .rdata (rdata0),
      .ready (ready0),
      .err   (err0),
      .busy  (busy0)
   );

   // ---------------- model ----------------
   bit          m_act   [2] = '{0, 0};
   bit          m_ready [2] = '{0, 0};
   bit          m_err   [2] = '{0, 0};
   bit          m_busy  [2] = '{0, 0};
   int          m_k     [2] = '{0, 0};
   logic [31:0] m_rdata [2] = '{0, 0};
   bit          m_rknown[2] = '{1, 1};
   logic [31:0] m_mem   [2][64];
   bit          m_val   [2][64];
   bit          p_we    [2];
   int          p_idx   [2];
   logic [31:0] p_data  [2];
   bit          p_fault [2];

   task automatic fire(input int i);
      m_ready[i] = 1'b1;
      m_err[i]   = p_fault[i];
      if (!p_we[i] && !p_fault[i]) begin
         m_rdata[i]  = m_mem[i][p_idx[i]];
         m_rknown[i] = m_val[i][p_idx[i]];
      end
   endtask

   task automatic step(input int i, input logic rq, input logic w,
                       input logic [31:0] a, input logic [31:0] d,
                       input int wt);
      if (!m_act[i]) begin
         if (rq) begin
            p_we[i]    = w;
            p_data[i]  = d;
            p_fault[i] = (a % 4 != 0) || (a >= 32'd256);
            p_idx[i]   = p_fault[i] ? 0 : int'(a / 4);
            m_act[i]   = 1'b1;
            m_busy[i]  = 1'b1;
            m_k[i]     = p_fault[i] ? 0 : wt;
            if (m_k[i] == 0) fire(i);
         end
      end else if (m_ready[i]) begin
         if (p_we[i] && !p_fault[i]) begin
            m_mem[i][p_idx[i]] = p_data[i];
            m_val[i][p_idx[i]] = 1'b1;
         end
         m_act[i]   = 1'b0;
         m_ready[i] = 1'b0;
         m_err[i]   = 1'b0;
         m_busy[i]  = 1'b0;
      end else begin
         m_k[i] = m_k[i] - 1;
         if (m_k[i] == 0) fire(i);
      end
   endtask

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < 2; i++) begin
            m_act[i]    = 1'b0;
            m_ready[i]  = 1'b0;
            m_err[i]    = 1'b0;
            m_busy[i]   = 1'b0;
            m_k[i]      = 0;
            m_rdata[i]  = 32'd0;
            m_rknown[i] = 1'b1;
         end
      end else begin
         step(0, req0, we0, adr0, wdata0, 0);
         step(1, req1, we1, adr1, wdata1, 2);
      end
   end

   // ---------------- checking ----------------
   task automatic check(input string nm, input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp,
                  $time);
      end
   endtask

   task automatic cmp(input int i, input logic rdy, input logic e,
                      input logic b, input logic [31:0] rd);
      check($sformatf("ready%0d", i), 32'(rdy), 32'(m_ready[i]));
      check($sformatf("busy%0d", i), 32'(b), 32'(m_busy[i]));
      if (m_ready[i]) check($sformatf("err%0d", i), 32'(e), 32'(m_err[i]));
      if (m_rknown[i]) check($sformatf("rdata%0d", i), rd, m_rdata[i]);
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         cmp(0, ready0, err0, busy0, rdata0);
         cmp(1, ready1, err1, busy1, rdata1);
      end
   end

   // ---------------- stimulus ----------------
   task automatic wait_rdy1(inout int lat, inout int bc);
      bit got;
      got = 1'b0;
      for (int n = 0; n < 40 && !got; n++) begin
         @(negedge clk);
         lat++;
         if (busy1) bc++;
         if (ready1) got = 1'b1;
      end
      if (!got) check("timeout1", 32'd0, 32'd1);
      req1 = 1'b0;
   endtask

   task automatic access1(input logic w, input logic [31:0] a,
                          input logic [31:0] d, output int lat,
                          output int bc);
      @(negedge clk);
      req1 = 1'b1; we1 = w; adr1 = a; wdata1 = d;
      lat = 0; bc = 0;
      wait_rdy1(lat, bc);
   endtask

   task automatic access0(input logic w, input logic [31:0] a,
                          input logic [31:0] d, output int lat);
      bit got;
      @(negedge clk);
      req0 = 1'b1; we0 = w; adr0 = a; wdata0 = d;
      lat = 0; got = 1'b0;
      for (int n = 0; n < 40 && !got; n++) begin
         @(negedge clk);
         lat++;
         if (ready0) got = 1'b1;
      end
      if (!got) check("timeout0", 32'd0, 32'd1);
      req0 = 1'b0;
   endtask

   initial begin
      int lat, bc, cnt;
      #1 reset = 1'b0;
      #1 chk_en = 1'b1;
      @(negedge clk);
      check("rst_ready", 32'(ready1), 32'd0);
      check("rst_err", 32'(err1), 32'd0);
      check("rst_busy", 32'(busy1), 32'd0);
      check("rst_rdata", rdata1, 32'd0);
      #2 reset = 1'b1;

      access1(1'b1, 32'h10, 32'hDEADBEEF, lat, bc);
      check("wr_lat", 32'(lat), 32'd3);
      check("wr_busy_cycles", 32'(bc), 32'd3);
      check("wr_err", 32'(err1), 32'd0);

      access1(1'b0, 32'h10, 32'h0, lat, bc);
      check("rd_lat", 32'(lat), 32'd3);
      check("rd_data", rdata1, 32'hDEADBEEF);

      access1(1'b1, 32'h13, 32'h1111_1111, lat, bc);
      check("mis_lat", 32'(lat), 32'd1);
      check("mis_err", 32'(err1), 32'd1);
      check("mis_rdata_hold", rdata1, 32'hDEADBEEF);
      access1(1'b1, 32'h400, 32'h2222_2222, lat, bc);
      check("oor_lat", 32'(lat), 32'd1);
      check("oor_err", 32'(err1), 32'd1);
      access1(1'b0, 32'h10, 32'h0, lat, bc);
      check("w4_data", rdata1, 32'hDEADBEEF);

      // Latched request must ignore later input changes.
      access1(1'b1, 32'h3C, 32'h3C3C3C3C, lat, bc);
      @(negedge clk);
      req1 = 1'b1; we1 = 1'b1; adr1 = 32'h8; wdata1 = 32'hA5A5A5A5;
      @(negedge clk);
      adr1 = 32'h3C; wdata1 = 32'h0;
      lat = 1; bc = 1;
      wait_rdy1(lat, bc);
      check("tog_lat", 32'(lat), 32'd3);
      access1(1'b0, 32'h8, 32'h0, lat, bc);
      check("tog_rd8", rdata1, 32'hA5A5A5A5);
      access1(1'b0, 32'h3C, 32'h0, lat, bc);
      check("tog_rd3c", rdata1, 32'h3C3C3C3C);

      // Reset in WAITS discards a pending write.
      access1(1'b1, 32'h20, 32'h0BADF00D, lat, bc);
      @(negedge clk);
      req1 = 1'b1; we1 = 1'b1; adr1 = 32'h20; wdata1 = 32'h12345678;
      @(negedge clk);
      check("mid_busy", 32'(busy1), 32'd1);
      #2 reset = 1'b0;
      #1;
      check("mid_ready", 32'(ready1), 32'd0);
      check("mid_busy0", 32'(busy1), 32'd0);
      check("mid_err", 32'(err1), 32'd0);
      check("mid_rdata", rdata1, 32'd0);
      req1 = 1'b0;
      @(negedge clk);
      #2 reset = 1'b1;
      access1(1'b0, 32'h20, 32'h0, lat, bc);
      check("mid_old", rdata1, 32'h0BADF00D);

      // WAIT=0 instance: back-to-back reads with req held.
      access0(1'b1, 32'h0, 32'h11111111, lat);
      check("w0_lat", 32'(lat), 32'd1);
      access0(1'b1, 32'h4, 32'h22222222, lat);
      @(negedge clk);
      req0 = 1'b1; we0 = 1'b0; adr0 = 32'h0;
      cnt = 0;
      for (int n = 0; n < 8; n++) begin
         @(negedge clk);
         if (ready0) begin
            cnt++;
            adr0 = adr0 ^ 32'h4;
         end
      end
      req0 = 1'b0;
      check("w0_b2b_count", 32'(cnt), 32'd4);
      access0(1'b0, 32'h4, 32'h0, lat);
      check("w0_rd4", rdata0, 32'h22222222);
      access0(1'b0, 32'h101, 32'h0, lat);
      check("w0_flt_lat", 32'(lat), 32'd1);
      check("w0_flt_err", 32'(err0), 32'd1);

      repeat (3) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
